// File: rtl/uart_host_ctrl.sv
// Bus-side master for the COREUART register interface: turns TX/RX byte streams
// into single-cycle CSN/WEN/OEN accesses and keeps per-byte and sticky error status.
module uart_host_ctrl #(
  parameter int HOLD_CYC = 2,
  parameter int ARB_MODE = 0
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic [2:0]  rx_err,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [2:0]  err_sticky,
  input  logic        err_clr,
  output logic [15:0] tx_count,
  output logic [15:0] rx_count,
  output logic        UART_CSN,
  output logic        UART_WEN,
  output logic        UART_OEN,
  output logic [7:0]  UART_DATA_IN,
  input  logic [7:0]  UART_DATA_OUT,
  input  logic        UART_TXRDY,
  input  logic        UART_RXRDY,
  input  logic        UART_PARITY_ERR,
  input  logic        UART_OVERFLOW,
  input  logic        UART_FRAMING_ERR
);
  // state | meaning
  // IDLE  | strobes inactive, arbitrating tx_req against rx_req
  // WR    | CSN/WEN low for one cycle, UART_DATA_IN holds the byte
  // RD    | CSN/OEN low for one cycle, DATA_OUT and status sampled at its end
  // HOLD  | HOLD_CYC settle cycles before the next grant
  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD, ST_HOLD} state_t;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYC - 1);

  state_t      state_q, state_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic        rr_rx_q, rr_rx_d;
  logic        csn_q, csn_d, wen_q, wen_d, oen_q, oen_d;
  logic [7:0]  data_in_q, data_in_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic [2:0]  rx_err_q, rx_err_d;
  logic        rx_valid_q, rx_valid_d;
  logic [2:0]  err_sticky_q, err_sticky_d;
  logic [15:0] tx_count_q, tx_count_d;
  logic [15:0] rx_count_q, rx_count_d;

  logic        tx_req, rx_req, grant_rx, grant_tx;
  logic [2:0]  err_new;

  assign tx_req   = tx_valid & UART_TXRDY;
  assign rx_req   = UART_RXRDY & ~rx_valid_q;
  // Contested grants go to RX in fixed mode, otherwise to whichever side the pointer favours.
  assign grant_rx = rx_req & (~tx_req | (ARB_MODE == 1) | rr_rx_q);
  assign grant_tx = tx_req & ~grant_rx;
  assign err_new  = {UART_FRAMING_ERR, UART_OVERFLOW, UART_PARITY_ERR};

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      hold_cnt_q   <= '0;
      rr_rx_q      <= 1'b1;
      csn_q        <= 1'b1;
      wen_q        <= 1'b1;
      oen_q        <= 1'b1;
      data_in_q    <= '0;
      rx_data_q    <= '0;
      rx_err_q     <= '0;
      rx_valid_q   <= 1'b0;
      err_sticky_q <= '0;
      tx_count_q   <= '0;
      rx_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      rr_rx_q      <= rr_rx_d;
      csn_q        <= csn_d;
      wen_q        <= wen_d;
      oen_q        <= oen_d;
      data_in_q    <= data_in_d;
      rx_data_q    <= rx_data_d;
      rx_err_q     <= rx_err_d;
      rx_valid_q   <= rx_valid_d;
      err_sticky_q <= err_sticky_d;
      tx_count_q   <= tx_count_d;
      rx_count_q   <= rx_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rr_rx_d    = rr_rx_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_rx) begin
          state_d = ST_RD;
          rr_rx_d = 1'b0;
        end else if (grant_tx) begin
          state_d = ST_WR;
          rr_rx_d = 1'b1;
        end
      end
      ST_WR, ST_RD: begin
        if (HOLD_CYC == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d    = ST_HOLD;
          hold_cnt_d = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == 4'd0) state_d = ST_IDLE;
        else                    hold_cnt_d = hold_cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes come from the next state so they leave a flop cleanly.
  always_comb begin
    csn_d        = !((state_d == ST_WR) || (state_d == ST_RD));
    wen_d        = (state_d != ST_WR);
    oen_d        = (state_d != ST_RD);
    data_in_d    = data_in_q;
    rx_data_d    = rx_data_q;
    rx_err_d     = rx_err_q;
    rx_valid_d   = rx_valid_q;
    tx_count_d   = tx_count_q;
    rx_count_d   = rx_count_q;
    err_sticky_d = err_clr ? 3'b000 : err_sticky_q;
    if (tx_ready) data_in_d = tx_data;
    if (state_q == ST_WR) tx_count_d = tx_count_q + 16'd1;
    if (state_q == ST_RD) begin
      rx_data_d    = UART_DATA_OUT;
      rx_err_d     = err_new;
      rx_valid_d   = 1'b1;
      rx_count_d   = rx_count_q + 16'd1;
      err_sticky_d = err_sticky_d | err_new;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  assign tx_ready     = (state_q == ST_IDLE) && grant_tx;
  assign UART_CSN     = csn_q;
  assign UART_WEN     = wen_q;
  assign UART_OEN     = oen_q;
  assign UART_DATA_IN = data_in_q;
  assign rx_data      = rx_data_q;
  assign rx_err       = rx_err_q;
  assign rx_valid     = rx_valid_q;
  assign err_sticky   = err_sticky_q;
  assign tx_count     = tx_count_q;
  assign rx_count     = rx_count_q;

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Scoreboard bench for uart_host_ctrl: three instances (HOLD/ARB variants) share
// stimulus; the monitor checks whichever instance is currently in focus.
module tb_uart_host_ctrl;
  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       rx_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] UART_DATA_OUT = '0;
  logic       UART_TXRDY = 1'b1;
  logic       UART_RXRDY = 1'b0;
  logic       UART_PARITY_ERR = 1'b0;
  logic       UART_OVERFLOW = 1'b0;
  logic       UART_FRAMING_ERR = 1'b0;

  logic [2:0]  csn_w, wen_w, oen_w, txr_w, rxv_w;
  logic [7:0]  din_w[3];
  logic [7:0]  rxd_w[3];
  logic [2:0]  rxe_w[3];
  logic [2:0]  stk_w[3];
  logic [15:0] txc_w[3];
  logic [15:0] rxc_w[3];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_host_ctrl #(
      .HOLD_CYC(g == 0 ? 2 : (g == 1 ? 1 : 0)),
      .ARB_MODE(g == 1 ? 1 : 0)
    ) u_dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(txr_w[g]),
      .rx_data(rxd_w[g]), .rx_err(rxe_w[g]), .rx_valid(rxv_w[g]), .rx_ready(rx_ready),
      .err_sticky(stk_w[g]), .err_clr(err_clr),
      .tx_count(txc_w[g]), .rx_count(rxc_w[g]),
      .UART_CSN(csn_w[g]), .UART_WEN(wen_w[g]), .UART_OEN(oen_w[g]),
      .UART_DATA_IN(din_w[g]), .UART_DATA_OUT(UART_DATA_OUT),
      .UART_TXRDY(UART_TXRDY), .UART_RXRDY(UART_RXRDY),
      .UART_PARITY_ERR(UART_PARITY_ERR), .UART_OVERFLOW(UART_OVERFLOW),
      .UART_FRAMING_ERR(UART_FRAMING_ERR)
    );
  end

  typedef struct packed {logic wr; logic [7:0] d;} acc_t;
  acc_t        exp_acc[$];
  logic [10:0] exp_rx[$];

  int n_checks = 0;
  int n_fail = 0;
  int foc = 0;
  int cyc_cnt = 0;
  int mon_n = 0;
  int mon_first = 0;
  int mon_last = 0;

  always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

  function automatic int hold_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s dut=%0d actual=0x%0h required=0x%0h", name, foc, act, req);
    end
  endtask

  // Monitor: every access strobe and every rx handshake of the focused instance
  always @(negedge CLK) begin
    acc_t        e;
    logic [10:0] r;
    if (csn_w[foc] == 1'b0) begin
      n_checks++;
      if (exp_acc.size() == 0) begin
        n_fail++;
        $display("FAIL acc_unexpected dut=%0d wen=%b oen=%b din=0x%0h", foc, wen_w[foc], oen_w[foc], din_w[foc]);
      end else begin
        e = exp_acc.pop_front();
        if (e.wr ? !(wen_w[foc] == 1'b0 && oen_w[foc] == 1'b1 && din_w[foc] == e.d)
                 : !(oen_w[foc] == 1'b0 && wen_w[foc] == 1'b1)) begin
          n_fail++;
          $display("FAIL acc_match dut=%0d actual wen=%b oen=%b din=0x%0h required wr=%b din=0x%0h",
                   foc, wen_w[foc], oen_w[foc], din_w[foc], e.wr, e.d);
        end
      end
      if (mon_n > 0) begin
        n_checks++;
        if (cyc_cnt - mon_last < hold_of(foc) + 2) begin
          n_fail++;
          $display("FAIL acc_spacing dut=%0d actual=%0d required>=%0d", foc, cyc_cnt - mon_last, hold_of(foc) + 2);
        end
      end
      if (mon_n == 0) mon_first = cyc_cnt;
      mon_last = cyc_cnt;
      mon_n++;
    end
    if (rxv_w[foc] && rx_ready) begin
      n_checks++;
      if (exp_rx.size() == 0) begin
        n_fail++;
        $display("FAIL rx_unexpected dut=%0d data=0x%0h err=%b", foc, rxd_w[foc], rxe_w[foc]);
      end else begin
        r = exp_rx.pop_front();
        if ({rxd_w[foc], rxe_w[foc]} !== r) begin
          n_fail++;
          $display("FAIL rx_match dut=%0d actual data=0x%0h err=%b required data=0x%0h err=%b",
                   foc, rxd_w[foc], rxe_w[foc], r[10:3], r[2:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    tx_valid = 1'b0; UART_RXRDY = 1'b0; UART_TXRDY = 1'b1; rx_ready = 1'b0; err_clr = 1'b0;
    UART_PARITY_ERR = 1'b0; UART_OVERFLOW = 1'b0; UART_FRAMING_ERR = 1'b0;
    repeat (3) tick();
    RESET_N = 1'b1;
    mon_n = 0;
  endtask

  task automatic push_w(input logic [7:0] d);
    acc_t e;
    e.wr = 1'b1; e.d = d;
    exp_acc.push_back(e);
  endtask

  task automatic push_r(input logic [7:0] d, input logic [2:0] er);
    acc_t e;
    e.wr = 1'b0; e.d = 8'h00;
    exp_acc.push_back(e);
    exp_rx.push_back({d, er});
  endtask

  // Streams n_rd reads and n_wr writes, following the focused instance's handshakes
  task automatic run_stream(input int n_rd, input int n_wr, input logic [7:0] tx_base,
                            input logic [7:0] rx_base, input int budget);
    int   rd_done = 0;
    int   wr_done = 0;
    int   cyc = 0;
    logic acc_w, acc_r;
    tx_data = tx_base; tx_valid = (n_wr > 0); UART_TXRDY = 1'b1;
    UART_DATA_OUT = rx_base; UART_RXRDY = (n_rd > 0); rx_ready = 1'b1;
    while ((rd_done < n_rd || wr_done < n_wr) && cyc < budget) begin
      @(negedge CLK);
      acc_w = tx_valid && txr_w[foc];
      acc_r = (oen_w[foc] == 1'b0);
      tick();
      cyc++;
      if (acc_w) begin
        wr_done++;
        if (wr_done < n_wr) tx_data = tx_base + 8'(wr_done);
        else                tx_valid = 1'b0;
      end
      if (acc_r) begin
        rd_done++;
        if (rd_done < n_rd) UART_DATA_OUT = rx_base + 8'(rd_done);
        else                UART_RXRDY = 1'b0;
      end
    end
    chk("stream_done", 32'(rd_done == n_rd && wr_done == n_wr), 32'd1);
    repeat (8) tick();
  endtask

  task automatic wait_oen(input int budget);
    logic seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge CLK);
      seen = (oen_w[foc] == 1'b0);
    end
    chk("oen_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state of every instance
    RESET_N = 1'b0;
    tx_valid = 1'b1; tx_data = 8'hEE; UART_RXRDY = 1'b1;
    repeat (3) tick();
    @(negedge CLK);
    for (int g = 0; g < 3; g++) begin
      chk("rst_strobes", 32'({csn_w[g], wen_w[g], oen_w[g]}), 32'h7);
      chk("rst_data_in", 32'(din_w[g]), 32'h0);
      chk("rst_rx", 32'({rxv_w[g], rxd_w[g], rxe_w[g]}), 32'h0);
      chk("rst_sticky", 32'(stk_w[g]), 32'h0);
      chk("rst_counts", {txc_w[g], rxc_w[g]}, 32'h0);
    end

    // Single write, HOLD_CYC=2
    do_reset();
    foc = 0;
    push_w(8'h5A);
    tx_data = 8'h5A; tx_valid = 1'b1;
    @(negedge CLK);
    chk("tx_ready_pulse", 32'(txr_w[0]), 32'd1);
    tick();
    tx_valid = 1'b0;
    @(negedge CLK);
    chk("wr_latency", 32'({csn_w[0], wen_w[0], oen_w[0], din_w[0]}), 32'h15A);
    repeat (6) tick();
    chk("tx_count_1", 32'(txc_w[0]), 32'd1);

    // Single read held while rx_ready is low
    push_r(8'hC3, 3'b000);
    UART_DATA_OUT = 8'hC3; UART_RXRDY = 1'b1; rx_ready = 1'b0;
    tick(); tick();
    @(negedge CLK);
    chk("rx_latency", 32'({rxv_w[0], rxd_w[0]}), 32'h1C3);
    repeat (10) tick();
    @(negedge CLK);
    chk("rx_held", 32'({rxv_w[0], rxd_w[0]}), 32'h1C3);
    chk("rx_count_1", 32'(rxc_w[0]), 32'd1);
    tick();
    rx_ready = 1'b1; UART_RXRDY = 1'b0;
    tick();
    rx_ready = 1'b0;
    @(negedge CLK);
    chk("rx_valid_clr", 32'(rxv_w[0]), 32'd0);

    // Round-robin: RD,WR alternating
    do_reset();
    foc = 0;
    for (int i = 0; i < 4; i++) begin
      push_r(8'h30 + 8'(i), 3'b000);
      push_w(8'hA0 + 8'(i));
    end
    run_stream(4, 4, 8'hA0, 8'h30, 200);
    chk("rr_counts", {txc_w[0], rxc_w[0]}, {16'd4, 16'd4});

    // Fixed RX-first: all reads first
    do_reset();
    foc = 1;
    for (int i = 0; i < 4; i++) push_r(8'h40 + 8'(i), 3'b000);
    for (int i = 0; i < 4; i++) push_w(8'hB0 + 8'(i));
    run_stream(4, 4, 8'hB0, 8'h40, 200);
    chk("fixed_counts", {txc_w[1], rxc_w[1]}, {16'd4, 16'd4});

    // HOLD_CYC=0: back-to-back writes every 2 cycles
    do_reset();
    foc = 2;
    for (int i = 0; i < 4; i++) push_w(8'hD0 + 8'(i));
    run_stream(0, 4, 8'hD0, 8'h00, 100);
    chk("b2b_n", 32'(mon_n), 32'd4);
    chk("b2b_span", 32'(mon_last - mon_first), 32'd6);

    // Error capture and sticky behaviour
    do_reset();
    foc = 0;
    rx_ready = 1'b1;
    push_r(8'h11, 3'b001);
    UART_DATA_OUT = 8'h11; UART_PARITY_ERR = 1'b1; UART_RXRDY = 1'b1;
    wait_oen(20);
    tick();
    UART_RXRDY = 1'b0; UART_PARITY_ERR = 1'b0;
    repeat (4) tick();
    @(negedge CLK);
    chk("parity_rx_err", 32'(rxe_w[0]), 32'h1);
    chk("parity_sticky", 32'(stk_w[0]), 32'h1);
    tick();
    push_r(8'h22, 3'b100);
    UART_DATA_OUT = 8'h22; UART_FRAMING_ERR = 1'b1; UART_RXRDY = 1'b1;
    wait_oen(20);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0; UART_RXRDY = 1'b0; UART_FRAMING_ERR = 1'b0;
    @(negedge CLK);
    chk("clr_vs_new_err", 32'(stk_w[0]), 32'h4);
    repeat (4) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge CLK);
    chk("err_clr_only", 32'(stk_w[0]), 32'h0);

    // Reset during the WR cycle
    do_reset();
    foc = 0;
    push_w(8'h77);
    tx_data = 8'h77; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0; RESET_N = 1'b0;
    tick();
    @(negedge CLK);
    chk("rst_mid_strobes", 32'({csn_w[0], wen_w[0], oen_w[0]}), 32'h7);
    chk("rst_mid_counts", 32'({txc_w[0], rxv_w[0]}), 32'h0);
    tick();
    RESET_N = 1'b1;
    repeat (5) tick();
    chk("rst_mid_no_reissue", 32'(txc_w[0]), 32'd0);

    chk("acc_queue_empty", 32'(exp_acc.size()), 32'd0);
    chk("rx_queue_empty", 32'(exp_rx.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
